exc_pipe_reg: RTL and testbench

- Parametrised E→M exception pipeline register with a CP0 request handshake.
- Merges the exception code carried from earlier stages with NUM_SRC execute-stage detectors (load/store misalignment, overflow, …) using fixed priority.
- Registers the winning code with PC/BD/BadVAddr across the E/M boundary, honouring stall and flush.
- Holds the first committed exception in a capture register until CP0 acknowledges it, then issues a one-cycle pipeline flush request.

---
 rtl/exc_pipe_reg_pkg.sv | 25 ++
 rtl/exc_pipe_reg_if.sv | 41 ++++
 rtl/exc_prio_enc.sv | 25 ++
 rtl/exc_pipe_reg.sv | 180 ++++++++++++++++++
 tb/tb_exc_pipe_reg.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/exc_pipe_reg_pkg.sv
// Shared ExcCode constants and E/M exception FSM encodings.
// Imported by the E/M exception register and its priority encoder.
package exc_pipe_reg_pkg;

  localparam int unsigned ExcCodeW = 5;

  localparam logic [ExcCodeW-1:0] ExcInt  = 5'd0;
  localparam logic [ExcCodeW-1:0] ExcAdel = 5'd4;
  localparam logic [ExcCodeW-1:0] ExcAdes = 5'd5;
  localparam logic [ExcCodeW-1:0] ExcRi   = 5'd10;
  localparam logic [ExcCodeW-1:0] ExcOv   = 5'd12;
  localparam logic [ExcCodeW-1:0] ExcNone = 5'h1f;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StReq   = 2'd1,
    StFlush = 2'd2
  } exc_state_e;

  // Index width for an n-way encoder; never zero so a 1-source build still has a bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/exc_pipe_reg_if.sv
// Pipeline/CP0 side signals of the E/M exception register.
// slave is the register itself, master is whoever drives the E stage and CP0.
interface exc_pipe_reg_if #(
  parameter int unsigned NUM_SRC = 3,
  parameter int unsigned CODE_W  = 5,
  parameter int unsigned ADDR_W  = 32
);

  logic               stall_i;
  logic               flush_i;
  logic               valid_i;
  logic [CODE_W-1:0]  exc_code_i;
  logic [ADDR_W-1:0]  pc_i;
  logic               bd_i;
  logic [ADDR_W-1:0]  addr_i;
  logic [NUM_SRC-1:0] src_req_i;
  logic               exc_ack_i;

  logic               valid_o;
  logic [CODE_W-1:0]  exc_code_o;
  logic               exc_req_o;
  logic [ADDR_W-1:0]  epc_o;
  logic               bd_o;
  logic [ADDR_W-1:0]  badvaddr_o;
  logic [CODE_W-1:0]  cause_o;
  logic               flush_req_o;
  logic               busy_o;

  modport slave (
    input  stall_i, flush_i, valid_i, exc_code_i, pc_i, bd_i, addr_i, src_req_i, exc_ack_i,
    output valid_o, exc_code_o, exc_req_o, epc_o, bd_o, badvaddr_o, cause_o, flush_req_o,
           busy_o
  );

  modport master (
    output stall_i, flush_i, valid_i, exc_code_i, pc_i, bd_i, addr_i, src_req_i, exc_ack_i,
    input  valid_o, exc_code_o, exc_req_o, epc_o, bd_o, badvaddr_o, cause_o, flush_req_o,
           busy_o
  );

endinterface

// File: rtl/exc_prio_enc.sv
// Fixed-priority encoder: lowest set request index wins.
module exc_prio_enc
  import exc_pipe_reg_pkg::*;
#(
  parameter int unsigned NumSrc = 3,
  parameter int unsigned IdxW   = idx_w(NumSrc)
) (
  input  logic [NumSrc-1:0] req_i,
  output logic [IdxW-1:0]   idx_o,
  output logic              hit_o
);

  // Scan from the top so the lowest index is the last to assign.
  always_comb begin
    idx_o = '0;
    hit_o = 1'b0;
    for (int i = NumSrc - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o = IdxW'(i);
        hit_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/exc_pipe_reg.sv
// E->M exception pipeline register: merges carried and execute-stage exception codes,
// registers them across E/M, and hands the oldest one to CP0 with a one-cycle flush.
module exc_pipe_reg
  import exc_pipe_reg_pkg::*;
#(
  parameter int unsigned                  NUM_SRC   = 3,
  parameter int unsigned                  CODE_W    = 5,
  parameter int unsigned                  ADDR_W    = 32,
  parameter logic [CODE_W-1:0]            EXC_NONE  = ExcNone,
  parameter logic [NUM_SRC*CODE_W-1:0]    SRC_CODES = {ExcOv, ExcAdes, ExcAdel}
) (
  input logic          clk,
  input logic          reset_n,
  exc_pipe_reg_if.slave bus
);

  localparam int unsigned IdxW = idx_w(NUM_SRC);

  logic [IdxW-1:0]   win_idx;
  logic              det_hit;
  logic              carried_hit;
  logic [CODE_W-1:0] det_code;
  logic [CODE_W-1:0] e_code;
  logic [ADDR_W-1:0] e_badaddr;
  logic [ADDR_W-1:0] e_epc;

  exc_prio_enc #(
    .NumSrc (NUM_SRC),
    .IdxW   (IdxW)
  ) u_prio (
    .req_i (bus.src_req_i),
    .idx_o (win_idx),
    .hit_o (det_hit)
  );

  assign carried_hit = (bus.exc_code_i != EXC_NONE);

  always_comb begin
    det_code = EXC_NONE;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (IdxW'(i) == win_idx) begin
        det_code = SRC_CODES[i*CODE_W +: CODE_W];
      end
    end
  end

  always_comb begin
    e_code    = EXC_NONE;
    e_badaddr = '0;
    if (carried_hit) begin
      e_code = bus.exc_code_i;
      // A carried AdEL can only come from instruction fetch, so the bad address is the PC.
      if (bus.exc_code_i == SRC_CODES[0 +: CODE_W]) begin
        e_badaddr = bus.pc_i;
      end
    end else if (det_hit) begin
      e_code    = det_code;
      e_badaddr = bus.addr_i;
    end
    if (!bus.valid_i) begin
      e_code = EXC_NONE;
    end
  end

  assign e_epc = bus.bd_i ? (bus.pc_i - ADDR_W'(4)) : bus.pc_i;

  // E/M register
  exc_state_e        state_q;
  logic              m_valid_q, m_valid_d;
  logic [CODE_W-1:0] m_code_q, m_code_d;
  logic [ADDR_W-1:0] m_epc_q, m_epc_d;
  logic              m_bd_q, m_bd_d;
  logic [ADDR_W-1:0] m_badaddr_q, m_badaddr_d;
  logic              bubble;

  assign bubble = (state_q != StIdle) || bus.flush_i;

  always_comb begin
    m_valid_d   = m_valid_q;
    m_code_d    = m_code_q;
    m_epc_d     = m_epc_q;
    m_bd_d      = m_bd_q;
    m_badaddr_d = m_badaddr_q;
    if (bubble) begin
      m_valid_d = 1'b0;
      m_code_d  = EXC_NONE;
    end else if (!bus.stall_i) begin
      m_valid_d   = bus.valid_i;
      m_code_d    = e_code;
      m_epc_d     = e_epc;
      m_bd_d      = bus.bd_i;
      m_badaddr_d = e_badaddr;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_valid_q   <= 1'b0;
      m_code_q    <= EXC_NONE;
      m_epc_q     <= '0;
      m_bd_q      <= 1'b0;
      m_badaddr_q <= '0;
    end else begin
      m_valid_q   <= m_valid_d;
      m_code_q    <= m_code_d;
      m_epc_q     <= m_epc_d;
      m_bd_q      <= m_bd_d;
      m_badaddr_q <= m_badaddr_d;
    end
  end

  // CP0 request FSM with registered outputs
  logic              exc_req_q;
  logic              flush_req_q;
  logic              busy_q;
  logic [ADDR_W-1:0] cap_epc_q;
  logic              cap_bd_q;
  logic [ADDR_W-1:0] cap_badaddr_q;
  logic [CODE_W-1:0] cap_cause_q;
  logic              capture;

  // Capture sees the pre-edge M contents, so a same-edge flush_i cannot hide it.
  assign capture = m_valid_q && (m_code_q != EXC_NONE) && !bus.stall_i;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      exc_req_q     <= 1'b0;
      flush_req_q   <= 1'b0;
      busy_q        <= 1'b0;
      cap_epc_q     <= '0;
      cap_bd_q      <= 1'b0;
      cap_badaddr_q <= '0;
      cap_cause_q   <= EXC_NONE;
    end else begin
      case (state_q)
        StIdle: begin
          if (capture) begin
            state_q       <= StReq;
            exc_req_q     <= 1'b1;
            busy_q        <= 1'b1;
            cap_epc_q     <= m_epc_q;
            cap_bd_q      <= m_bd_q;
            cap_badaddr_q <= m_badaddr_q;
            cap_cause_q   <= m_code_q;
          end
        end
        StReq: begin
          if (bus.exc_ack_i) begin
            state_q     <= StFlush;
            exc_req_q   <= 1'b0;
            flush_req_q <= 1'b1;
          end
        end
        StFlush: begin
          state_q     <= StIdle;
          flush_req_q <= 1'b0;
          busy_q      <= 1'b0;
        end
        default: begin
          state_q     <= StIdle;
          exc_req_q   <= 1'b0;
          flush_req_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.valid_o     = m_valid_q;
  assign bus.exc_code_o  = m_code_q;
  assign bus.exc_req_o   = exc_req_q;
  assign bus.epc_o       = cap_epc_q;
  assign bus.bd_o        = cap_bd_q;
  assign bus.badvaddr_o  = cap_badaddr_q;
  assign bus.cause_o     = cap_cause_q;
  assign bus.flush_req_o = flush_req_q;
  assign bus.busy_o      = busy_q;

endmodule

// File: tb/tb_exc_pipe_reg.sv
// Directed bench for exc_pipe_reg: priority merge, EPC/BD, CP0 handshake, stall/flush, reset.
module tb_exc_pipe_reg;

  localparam logic [4:0] NONE = 5'h1f;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  exc_pipe_reg_if bus ();

  exc_pipe_reg dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_e();
    bus.valid_i    = 1'b0;
    bus.exc_code_i = NONE;
    bus.src_req_i  = '0;
    bus.pc_i       = '0;
    bus.bd_i       = 1'b0;
    bus.addr_i     = '0;
  endtask

  task automatic set_e(input logic [4:0] code, input logic [2:0] src, input logic [31:0] pc,
                       input logic bd, input logic [31:0] addr);
    bus.valid_i    = 1'b1;
    bus.exc_code_i = code;
    bus.src_req_i  = src;
    bus.pc_i       = pc;
    bus.bd_i       = bd;
    bus.addr_i     = addr;
  endtask

  task automatic ack_seq(input string tag);
    bus.exc_ack_i = 1'b1;
    tick();
    chk({tag, "_flush_pulse"}, 32'(bus.flush_req_o), 32'd1);
    chk({tag, "_req_drop"}, 32'(bus.exc_req_o), 32'd0);
    bus.exc_ack_i = 1'b0;
    tick();
    chk({tag, "_flush_end"}, 32'(bus.flush_req_o), 32'd0);
    chk({tag, "_idle"}, 32'(bus.busy_o), 32'd0);
  endtask

  initial begin
    reset_n       = 1'b0;
    bus.stall_i   = 1'b0;
    bus.flush_i   = 1'b0;
    bus.exc_ack_i = 1'b0;
    idle_e();
    #12;
    chk("rst_valid", 32'(bus.valid_o), 32'd0);
    chk("rst_code", 32'(bus.exc_code_o), 32'(NONE));
    chk("rst_req", 32'(bus.exc_req_o), 32'd0);
    chk("rst_epc", bus.epc_o, 32'd0);
    chk("rst_bd", 32'(bus.bd_o), 32'd0);
    chk("rst_badvaddr", bus.badvaddr_o, 32'd0);
    chk("rst_cause", 32'(bus.cause_o), 32'(NONE));
    chk("rst_flush", 32'(bus.flush_req_o), 32'd0);
    chk("rst_busy", 32'(bus.busy_o), 32'd0);
    #8 reset_n = 1'b1;
    tick();

    // Overflow only: code in M at n+1, request at n+2
    set_e(NONE, 3'b100, 32'h3000, 1'b0, 32'h0);
    tick();
    idle_e();
    chk("ov_m_code", 32'(bus.exc_code_o), 32'd12);
    chk("ov_m_valid", 32'(bus.valid_o), 32'd1);
    chk("ov_no_early_req", 32'(bus.exc_req_o), 32'd0);
    tick();
    chk("ov_req", 32'(bus.exc_req_o), 32'd1);
    chk("ov_epc", bus.epc_o, 32'h3000);
    chk("ov_cause", 32'(bus.cause_o), 32'd12);
    chk("ov_badvaddr", bus.badvaddr_o, 32'd0);
    chk("ov_bd", 32'(bus.bd_o), 32'd0);
    chk("ov_busy", 32'(bus.busy_o), 32'd1);
    ack_seq("ov");

    // Carried RI beats every detector
    set_e(5'd10, 3'b111, 32'h4000, 1'b0, 32'h1003);
    tick();
    idle_e();
    tick();
    chk("ri_cause", 32'(bus.cause_o), 32'd10);
    chk("ri_badvaddr", bus.badvaddr_o, 32'd0);
    chk("ri_epc", bus.epc_o, 32'h4000);
    ack_seq("ri");

    // Detector 1 (AdES) beats detector 2
    set_e(NONE, 3'b110, 32'h4010, 1'b0, 32'h1003);
    tick();
    idle_e();
    tick();
    chk("ades_cause", 32'(bus.cause_o), 32'd5);
    chk("ades_badvaddr", bus.badvaddr_o, 32'h1003);
    chk("ades_epc", bus.epc_o, 32'h4010);
    ack_seq("ades");

    // Carried fetch AdEL in a delay slot
    set_e(5'd4, 3'b000, 32'h3004, 1'b1, 32'h55);
    tick();
    idle_e();
    tick();
    chk("ds_epc", bus.epc_o, 32'h3000);
    chk("ds_bd", 32'(bus.bd_o), 32'd1);
    chk("ds_cause", 32'(bus.cause_o), 32'd4);
    chk("ds_badvaddr_pc", bus.badvaddr_o, 32'h3004);
    ack_seq("ds");

    // EPC wraps below zero
    set_e(NONE, 3'b001, 32'h0, 1'b1, 32'h77);
    tick();
    idle_e();
    tick();
    chk("wrap_epc", bus.epc_o, 32'hFFFF_FFFC);
    chk("wrap_badvaddr", bus.badvaddr_o, 32'h77);
    chk("wrap_cause", 32'(bus.cause_o), 32'd4);
    ack_seq("wrap");

    // Request held without ack; younger exceptions bubbled
    set_e(NONE, 3'b100, 32'h5000, 1'b0, 32'h0);
    tick();
    idle_e();
    tick();
    chk("hs_req", 32'(bus.exc_req_o), 32'd1);
    set_e(NONE, 3'b001, 32'h9000, 1'b0, 32'h9999);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hs_req_hold", 32'(bus.exc_req_o), 32'd1);
      chk("hs_epc_hold", bus.epc_o, 32'h5000);
      chk("hs_cause_hold", 32'(bus.cause_o), 32'd12);
      chk("hs_bubble", 32'(bus.valid_o), 32'd0);
      chk("hs_no_flush", 32'(bus.flush_req_o), 32'd0);
    end
    idle_e();
    bus.exc_ack_i = 1'b1;
    tick();
    chk("hs_flush", 32'(bus.flush_req_o), 32'd1);
    tick();
    chk("hs_flush_once", 32'(bus.flush_req_o), 32'd0);
    chk("hs_idle", 32'(bus.busy_o), 32'd0);
    tick();
    chk("hs_ack_ignored", 32'(bus.busy_o), 32'd0);
    chk("hs_ack_no_flush", 32'(bus.flush_req_o), 32'd0);
    bus.exc_ack_i = 1'b0;

    // Stall holds the M exception and delays capture
    set_e(NONE, 3'b100, 32'h6000, 1'b0, 32'h0);
    tick();
    idle_e();
    bus.stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("st_no_req", 32'(bus.exc_req_o), 32'd0);
      chk("st_code_held", 32'(bus.exc_code_o), 32'd12);
      chk("st_valid_held", 32'(bus.valid_o), 32'd1);
    end
    bus.stall_i = 1'b0;
    tick();
    chk("st_req", 32'(bus.exc_req_o), 32'd1);
    chk("st_epc", bus.epc_o, 32'h6000);
    ack_seq("st");

    // External flush kills the E-stage exception
    set_e(NONE, 3'b100, 32'h7000, 1'b0, 32'h0);
    bus.flush_i = 1'b1;
    tick();
    chk("fl_valid", 32'(bus.valid_o), 32'd0);
    chk("fl_code", 32'(bus.exc_code_o), 32'(NONE));
    bus.flush_i = 1'b0;
    idle_e();
    tick();
    chk("fl_no_req", 32'(bus.exc_req_o), 32'd0);
    chk("fl_not_busy", 32'(bus.busy_o), 32'd0);

    // Flush on the capture edge: capture still taken
    set_e(NONE, 3'b010, 32'h7100, 1'b0, 32'h2222);
    tick();
    idle_e();
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    chk("flc_req", 32'(bus.exc_req_o), 32'd1);
    chk("flc_cause", 32'(bus.cause_o), 32'd5);
    chk("flc_badvaddr", bus.badvaddr_o, 32'h2222);
    chk("flc_bubble", 32'(bus.valid_o), 32'd0);
    ack_seq("flc");

    // Async reset mid-request
    set_e(NONE, 3'b100, 32'h8000, 1'b0, 32'h0);
    tick();
    idle_e();
    tick();
    chk("ar_req_before", 32'(bus.exc_req_o), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_req", 32'(bus.exc_req_o), 32'd0);
    chk("ar_cause", 32'(bus.cause_o), 32'(NONE));
    chk("ar_busy", 32'(bus.busy_o), 32'd0);
    chk("ar_epc", bus.epc_o, 32'd0);
    #2 reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ar_no_flush", 32'(bus.flush_req_o), 32'd0);
      chk("ar_no_req", 32'(bus.exc_req_o), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
